// File: rtl/hpdcache_mem_req_id_alloc_if.sv
// Signal bundle between the requesters/memory side and the ID allocator.
// The "slave" modport is the allocator; "master" is everything around it.
interface hpdcache_mem_req_id_alloc_if #(
    parameter int N         = 2,
    parameter int ID_WIDTH  = 4,
    parameter int REQ_WIDTH = 64
);
    localparam int RT_DEPTH  = 2 ** ID_WIDTH;
    localparam int SEL_WIDTH = (N > 1) ? $clog2(N) : 1;

    // Handshakes: a transfer happens on a rising clk_i edge where valid and
    // ready are both high; a raised valid holds its payload until that edge.
    logic [N-1:0]                      req_valid_i;
    logic [N-1:0]                      req_ready_o;
    logic [N-1:0][REQ_WIDTH-1:0]       req_i;
    logic                              mem_req_valid_o;
    logic                              mem_req_ready_i;
    logic [REQ_WIDTH-1:0]              mem_req_o;
    logic [ID_WIDTH-1:0]               mem_req_id_o;
    logic                              resp_done_i;
    logic [ID_WIDTH-1:0]               resp_done_id_i;
    logic [RT_DEPTH-1:0][SEL_WIDTH-1:0] mem_resp_rt_o;
    logic                              id_full_o;
    logic [RT_DEPTH-1:0]               id_busy_o;
    // Round-robin pointer, exposed for observation.
    logic [SEL_WIDTH-1:0]              dbg_rr_ptr;

    modport slave (
        input  req_valid_i, req_i, mem_req_ready_i, resp_done_i, resp_done_id_i,
        output req_ready_o, mem_req_valid_o, mem_req_o, mem_req_id_o,
        output mem_resp_rt_o, id_full_o, id_busy_o, dbg_rr_ptr
    );

    modport master (
        output req_valid_i, req_i, mem_req_ready_i, resp_done_i, resp_done_id_i,
        input  req_ready_o, mem_req_valid_o, mem_req_o, mem_req_id_o,
        input  mem_resp_rt_o, id_full_o, id_busy_o, dbg_rr_ptr
    );
endinterface

// File: rtl/hpdcache_mem_req_id_alloc.sv
// Round-robin arbiter of N request channels onto one memory port; tags each
// granted request with the lowest free transaction ID and records its owner.
module hpdcache_mem_req_id_alloc #(
    parameter int N         = 2,
    parameter int ID_WIDTH  = 4,
    parameter int REQ_WIDTH = 64
) (
    input  logic clk_i,
    input  logic rst_ni,
    hpdcache_mem_req_id_alloc_if.slave bus
);
    localparam int RT_DEPTH  = 2 ** ID_WIDTH;
    localparam int SEL_WIDTH = (N > 1) ? $clog2(N) : 1;

    logic [RT_DEPTH-1:0]                busy_q, busy_d;
    logic [RT_DEPTH-1:0][SEL_WIDTH-1:0] rt_q;
    logic [SEL_WIDTH-1:0]               ptr_q, ptr_nxt;
    logic                               valid_q;
    logic [REQ_WIDTH-1:0]               data_q;
    logic [ID_WIDTH-1:0]                id_q;

    logic [ID_WIDTH-1:0]  free_id;
    logic                 has_free;
    logic [SEL_WIDTH-1:0] gnt_idx;
    logic [SEL_WIDTH-1:0] cand;
    logic                 any_valid;
    logic                 load_en;
    logic                 grant;

    assign load_en = !valid_q || bus.mem_req_ready_i;
    assign grant   = load_en && any_valid && has_free;

    // Lowest free ID, taken from the registered busy vector only, so an ID
    // freed this cycle cannot be handed out before the next one.
    always_comb begin
        free_id  = '0;
        has_free = 1'b0;
        for (int k = RT_DEPTH - 1; k >= 0; k--) begin
            if (!busy_q[k]) begin
                free_id  = ID_WIDTH'(k);
                has_free = 1'b1;
            end
        end
    end

    // Scan from the pointer; descending loop leaves the nearest valid winner.
    always_comb begin
        gnt_idx   = '0;
        any_valid = 1'b0;
        cand      = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (int'(ptr_q) + i >= N) begin
                cand = SEL_WIDTH'(int'(ptr_q) + i - N);
            end else begin
                cand = SEL_WIDTH'(int'(ptr_q) + i);
            end
            if (bus.req_valid_i[cand]) begin
                gnt_idx   = cand;
                any_valid = 1'b1;
            end
        end
    end

    always_comb begin
        if (int'(gnt_idx) == N - 1) begin
            ptr_nxt = '0;
        end else begin
            ptr_nxt = gnt_idx + SEL_WIDTH'(1);
        end
    end

    always_comb begin
        bus.req_ready_o = '0;
        if (grant) begin
            bus.req_ready_o[gnt_idx] = 1'b1;
        end
    end

    // A free of an idle ID is dropped; the granted ID is never the freed one
    // because it was free in busy_q while the freed one was busy.
    always_comb begin
        busy_d = busy_q;
        if (bus.resp_done_i && busy_q[bus.resp_done_id_i]) begin
            busy_d[bus.resp_done_id_i] = 1'b0;
        end
        if (grant) begin
            busy_d[free_id] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q  <= '0;
            rt_q    <= '0;
            ptr_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            id_q    <= '0;
        end else begin
            busy_q <= busy_d;
            if (grant) begin
                valid_q       <= 1'b1;
                data_q        <= bus.req_i[gnt_idx];
                id_q          <= free_id;
                rt_q[free_id] <= gnt_idx;
                ptr_q         <= ptr_nxt;
            end else if (load_en) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.mem_req_valid_o = valid_q;
    assign bus.mem_req_o       = data_q;
    assign bus.mem_req_id_o    = id_q;
    assign bus.mem_resp_rt_o   = rt_q;
    assign bus.id_busy_o       = busy_q;
    assign bus.id_full_o       = &busy_q;
    assign bus.dbg_rr_ptr      = ptr_q;

endmodule

// File: tb/tb_hpdcache_mem_req_id_alloc.sv
// Directed bench for hpdcache_mem_req_id_alloc (N=2, ID_WIDTH=4, 64-bit payload)
// with a reference model and an expected queue of {id, payload}.
module tb_hpdcache_mem_req_id_alloc;
    logic clk;
    logic rst_n;

    hpdcache_mem_req_id_alloc_if #(.N(2), .ID_WIDTH(4), .REQ_WIDTH(64)) bus ();

    hpdcache_mem_req_id_alloc #(.N(2), .ID_WIDTH(4), .REQ_WIDTH(64)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int passed = 0;

    // Reference model state
    logic [15:0] m_busy;
    logic [15:0] m_rt;
    logic        m_ptr;
    logic        m_valid;
    logic [63:0] m_data;
    logic [3:0]  m_id;

    logic [67:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_busy  = '0;
        m_rt    = '0;
        m_ptr   = 1'b0;
        m_valid = 1'b0;
        m_data  = '0;
        m_id    = '0;
        exp_q.delete();
    endtask

    task automatic check_state();
        chk("mem_valid", 64'(bus.mem_req_valid_o), 64'(m_valid));
        if (m_valid) begin
            chk("mem_data", bus.mem_req_o, m_data);
            chk("mem_id", 64'(bus.mem_req_id_o), 64'(m_id));
        end
        chk("busy", 64'(bus.id_busy_o), 64'(m_busy));
        chk("rt", 64'(bus.mem_resp_rt_o), 64'(m_rt));
        chk("full", 64'(bus.id_full_o), 64'(&m_busy));
        chk("ptr", 64'(bus.dbg_rr_ptr), 64'(m_ptr));
    endtask

    // Driver: apply one cycle of inputs, check the combinational grant,
    // advance the model across the edge, then check registered state.
    task automatic drive(input logic [1:0] v, input logic [63:0] p0, input logic [63:0] p1,
                         input logic mrdy, input logic done, input logic [3:0] did);
        logic        load_en;
        logic [3:0]  kk;
        logic        kfound;
        logic        g;
        logic        gfound;
        logic        c;
        logic [1:0]  exp_rdy;
        logic [63:0] pay;
        bus.req_valid_i     = v;
        bus.req_i[0]        = p0;
        bus.req_i[1]        = p1;
        bus.mem_req_ready_i = mrdy;
        bus.resp_done_i     = done;
        bus.resp_done_id_i  = did;
        #1;
        if (done) assert (m_busy[did]) else $error("FAIL free_idle: id %0d not outstanding", did);
        load_en = !m_valid || mrdy;
        kk = '0;
        kfound = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            if (!m_busy[4'(i)]) begin
                kk = 4'(i);
                kfound = 1'b1;
            end
        end
        g = 1'b0;
        gfound = 1'b0;
        for (int i = 1; i >= 0; i--) begin
            c = m_ptr ^ 1'(i);
            if (v[c]) begin
                g = c;
                gfound = 1'b1;
            end
        end
        exp_rdy = 2'b00;
        if (load_en && gfound && kfound) exp_rdy[g] = 1'b1;
        chk("req_ready", 64'(bus.req_ready_o), 64'(exp_rdy));
        if (exp_rdy != 2'b00) begin
            pay = g ? p1 : p0;
            exp_q.push_back({kk, pay});
            m_busy[kk] = 1'b1;
            m_rt[kk]   = g;
            m_ptr      = ~g;
            m_valid    = 1'b1;
            m_data     = pay;
            m_id       = kk;
        end else if (load_en) begin
            m_valid = 1'b0;
        end
        if (done) m_busy[did] = 1'b0;
        @(posedge clk);
        #1;
        check_state();
    endtask

    task automatic idle(input logic mrdy);
        drive(2'b00, 64'h0, 64'h0, mrdy, 1'b0, 4'h0);
    endtask

    task automatic do_reset();
        bus.req_valid_i     = '0;
        bus.mem_req_ready_i = 1'b1;
        bus.resp_done_i     = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        check_state();
    endtask

    // Scoreboard: a memory-side transfer completes at the next edge.
    always @(negedge clk) begin
        if (rst_n && bus.mem_req_valid_o && bus.mem_req_ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                $error("FAIL sb_unexpected: observed id %0h data %0h, expected no transfer",
                       bus.mem_req_id_o, bus.mem_req_o);
            end else begin
                logic [67:0] e;
                e = exp_q.pop_front();
                chk("sb_id", 64'(bus.mem_req_id_o), 64'(e[67:64]));
                chk("sb_data", bus.mem_req_o, e[63:0]);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        bus.req_valid_i     = '0;
        bus.req_i           = '0;
        bus.mem_req_ready_i = 1'b0;
        bus.resp_done_i     = 1'b0;
        bus.resp_done_id_i  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_state();
        chk("rst_mem_data", bus.mem_req_o, 64'h0);
        chk("rst_mem_id", 64'(bus.mem_req_id_o), 64'h0);
        rst_n = 1'b1;

        // Single request
        drive(2'b01, 64'hA5, 64'h0, 1'b1, 1'b0, 4'h0);
        chk("single_data", bus.mem_req_o, 64'hA5);
        chk("single_id", 64'(bus.mem_req_id_o), 64'h0);
        chk("single_busy", 64'(bus.id_busy_o), 64'h0001);
        idle(1'b1);

        // Round-robin: grants 0,1,0,1 with IDs 0..3
        do_reset();
        for (int i = 0; i < 4; i++)
            drive(2'b11, 64'({$urandom, $urandom}), 64'({$urandom, $urandom}), 1'b1, 1'b0, 4'h0);
        chk("rr_rt", 64'(bus.mem_resp_rt_o), 64'h000A);
        chk("rr_busy", 64'(bus.id_busy_o), 64'h000F);

        // Exhaustion: fill the remaining IDs, then a request must stall
        for (int i = 0; i < 12; i++)
            drive(2'b01, 64'(($urandom_range(1, 1000))), 64'h0, 1'b1, 1'b0, 4'h0);
        drive(2'b10, 64'h0, 64'h55, 1'b1, 1'b0, 4'h0);
        chk("exh_full", 64'(bus.id_full_o), 64'h1);
        chk("exh_ready", 64'(bus.req_ready_o), 64'h0);
        drive(2'b10, 64'h0, 64'h55, 1'b1, 1'b1, 4'h2);
        chk("exh_busy_after_free", 64'(bus.id_busy_o), 64'hFFFB);
        drive(2'b10, 64'h0, 64'h55, 1'b1, 1'b0, 4'h0);
        chk("exh_id", 64'(bus.mem_req_id_o), 64'h2);
        chk("exh_rt2", 64'(bus.mem_resp_rt_o[2]), 64'h1);

        // Free of ID 0 and a request in the same cycle while all IDs are busy
        drive(2'b01, 64'h77, 64'h0, 1'b1, 1'b1, 4'h0);
        chk("sim_busy", 64'(bus.id_busy_o), 64'hFFFE);
        drive(2'b01, 64'h77, 64'h0, 1'b1, 1'b0, 4'h0);
        chk("sim_id", 64'(bus.mem_req_id_o), 64'h0);
        idle(1'b1);

        // Backpressure: held output stays put, second requester waits
        do_reset();
        drive(2'b01, 64'h11, 64'h0, 1'b1, 1'b0, 4'h0);
        for (int i = 0; i < 3; i++)
            drive(2'b10, 64'h0, 64'h22, 1'b0, 1'b0, 4'h0);
        chk("bp_data_held", bus.mem_req_o, 64'h11);
        drive(2'b10, 64'h0, 64'h22, 1'b1, 1'b0, 4'h0);
        chk("bp_second_data", bus.mem_req_o, 64'h22);
        chk("bp_second_id", 64'(bus.mem_req_id_o), 64'h1);
        idle(1'b1);

        // Asynchronous reset with a held output and busy = 0x00F0
        do_reset();
        for (int i = 0; i < 7; i++)
            drive(2'b11, 64'(100 + i), 64'(200 + i), 1'b1, 1'b0, 4'h0);
        drive(2'b01, 64'h300, 64'h0, 1'b1, 1'b0, 4'h0);
        for (int i = 0; i < 4; i++)
            drive(2'b00, 64'h0, 64'h0, 1'b0, 1'b1, 4'(i));
        chk("pre_rst_busy", 64'(bus.id_busy_o), 64'h00F0);
        chk("pre_rst_ptr", 64'(bus.dbg_rr_ptr), 64'h1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_state();
        chk("async_rst_data", bus.mem_req_o, 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(2'b11, 64'hC0, 64'hC1, 1'b1, 1'b0, 4'h0);
        chk("post_rst_data", bus.mem_req_o, 64'hC0);
        idle(1'b1);
        chk("sb_drained", 64'(exp_q.size()), 64'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
